// File: rtl/sockit_cdc_fifo_if.sv
// Request/grant handshake bundle for sockit_cdc_fifo: ffi side accepts words, ffo side presents the head.
// The slave modport is the FIFO's view; master is the producer/consumer view.
interface sockit_cdc_fifo_if #(
    parameter int DW = 8
);
    logic [DW-1:0] ffi_bus;
    logic          ffi_req;
    logic          ffi_grt;
    logic [DW-1:0] ffo_bus;
    logic          ffo_req;
    logic          ffo_grt;

    modport slave (
        input  ffi_bus, ffi_req, ffo_grt,
        output ffi_grt, ffo_bus, ffo_req
    );

    modport master (
        output ffi_bus, ffi_req, ffo_grt,
        input  ffi_grt, ffo_bus, ffo_req
    );
endinterface

// File: rtl/sockit_cdc_fifo.sv
// Single-clock elastic FIFO sharing the crossing FIFO's gray-pointer handshake and latency.
// Define SOCKIT_CDC_SYNC_EN to insert SS pointer stages; otherwise pointers are compared directly.
module sockit_cdc_fifo #(
    parameter int FF = 4,
    parameter int SS = 2,
    parameter int DW = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    sockit_cdc_fifo_if.slave ff
);
    localparam int AW = $clog2(FF);
    localparam int PW = AW + 1;
    // Full when the pointers differ by exactly FF: gray codes match except the two MSBs.
    localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);

    function automatic logic [PW-1:0] bin2gry(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [DW-1:0] mem_q [FF];
    logic [PW-1:0] wr_bin_q, wr_bin_d;
    logic [PW-1:0] rd_bin_q, rd_bin_d;
    logic [PW-1:0] wr_gry_q, rd_gry_q;
    logic [PW-1:0] wr_gry_rd;
    logic [PW-1:0] rd_gry_wr;
    logic          ready_q;
    logic          full, empty;
    logic          wr_en, rd_en;

    assign full  = (wr_gry_q == (rd_gry_wr ^ FULL_MASK));
    assign empty = (rd_gry_q == wr_gry_rd);

    assign ff.ffi_grt = ready_q & ~full;
    assign ff.ffo_req = ~empty;
    assign ff.ffo_bus = mem_q[rd_bin_q[AW-1:0]];

    assign wr_en = ff.ffi_req & ready_q & ~full;
    assign rd_en = ff.ffo_grt & ~empty;

    always_comb begin
        wr_bin_d = wr_bin_q + {{(PW-1){1'b0}}, wr_en};
        rd_bin_d = rd_bin_q + {{(PW-1){1'b0}}, rd_en};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q  <= 1'b0;
            wr_bin_q <= '0;
            rd_bin_q <= '0;
            wr_gry_q <= '0;
            rd_gry_q <= '0;
        end else begin
            ready_q  <= 1'b1;
            wr_bin_q <= wr_bin_d;
            rd_bin_q <= rd_bin_d;
            wr_gry_q <= bin2gry(wr_bin_d);
            rd_gry_q <= bin2gry(rd_bin_d);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_bin_q[AW-1:0]] <= ff.ffi_bus;
        end
    end

`ifdef SOCKIT_CDC_SYNC_EN
    logic [PW-1:0] wr_sync_q [SS];
    logic [PW-1:0] rd_sync_q [SS];

    // Each side sees the other's pointer SS cycles late, as it would across clock domains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SS; i++) begin
                wr_sync_q[i] <= '0;
                rd_sync_q[i] <= '0;
            end
        end else begin
            wr_sync_q[0] <= wr_gry_q;
            rd_sync_q[0] <= rd_gry_q;
            for (int i = 1; i < SS; i++) begin
                wr_sync_q[i] <= wr_sync_q[i-1];
                rd_sync_q[i] <= rd_sync_q[i-1];
            end
        end
    end

    assign wr_gry_rd = wr_sync_q[SS-1];
    assign rd_gry_wr = rd_sync_q[SS-1];
`else
    // SS only gates elaboration here so the parameter list stays compatible with the crossing FIFO.
    if (SS >= 1) begin : g_direct
        assign wr_gry_rd = wr_gry_q;
        assign rd_gry_wr = rd_gry_q;
    end
`endif

endmodule

// File: tb/tb_sockit_cdc_fifo.sv
// Self-checking bench for sockit_cdc_fifo: directed handshake scenarios plus a randomized stream
// checked against an occupancy model where each side sees the other's count LAT cycles late.
module tb_sockit_cdc_fifo;
    localparam int FF = 4;
    localparam int SS = 2;
    localparam int DW = 8;
`ifdef SOCKIT_CDC_SYNC_EN
    localparam int LAT = SS;
`else
    localparam int LAT = 0;
`endif

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    sockit_cdc_fifo_if #(.DW(DW)) bus_if ();

    sockit_cdc_fifo #(.FF(FF), .SS(SS), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ff    (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (bus_if.ffi_grt !== 1'b0) begin
            errors++; $display("FAIL reset_grt: got %b expected 0", bus_if.ffi_grt);
        end
        checks++;
        if (bus_if.ffo_req !== 1'b0) begin
            errors++; $display("FAIL reset_req: got %b expected 0", bus_if.ffo_req);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus_if.ffi_grt !== 1'b0) begin
            errors++; $display("FAIL release_grt_before_edge: got %b expected 0", bus_if.ffi_grt);
        end
        @(negedge clk);
        checks++;
        if (bus_if.ffi_grt !== 1'b1) begin
            errors++; $display("FAIL release_grt_after_edge: got %b expected 1", bus_if.ffi_grt);
        end
        repeat (4) begin
            checks++;
            if (bus_if.ffo_req !== 1'b0) begin
                errors++; $display("FAIL idle_req: got %b expected 0", bus_if.ffo_req);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_single_word();
        bus_if.ffi_bus = 8'hA5;
        bus_if.ffi_req = 1'b1;
        @(negedge clk);
        bus_if.ffi_req = 1'b0;
        for (int k = 0; k <= LAT; k++) begin
            checks++;
            if (bus_if.ffo_req !== (k == LAT)) begin
                errors++;
                $display("FAIL single_latency: edge N+%0d ffo_req got %b expected %b", k, bus_if.ffo_req, (k == LAT));
            end
            if (k < LAT) @(negedge clk);
        end
        checks++;
        if (bus_if.ffo_bus !== 8'hA5) begin
            errors++; $display("FAIL single_data: got %h expected a5", bus_if.ffo_bus);
        end
        bus_if.ffo_grt = 1'b1;
        @(negedge clk);
        bus_if.ffo_grt = 1'b0;
        repeat (LAT + 2) begin
            checks++;
            if (bus_if.ffo_req !== 1'b0) begin
                errors++; $display("FAIL single_after_read: ffo_req got %b expected 0", bus_if.ffo_req);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < FF; i++) begin
            checks++;
            if (bus_if.ffi_grt !== 1'b1) begin
                errors++; $display("FAIL fill_grt: before write %0d got %b expected 1", i, bus_if.ffi_grt);
            end
            bus_if.ffi_req = 1'b1;
            bus_if.ffi_bus = DW'(i);
            @(negedge clk);
        end
        bus_if.ffi_bus = 8'h55;
        repeat (LAT + 3) begin
            checks++;
            if (bus_if.ffi_grt !== 1'b0) begin
                errors++; $display("FAIL full_grt: got %b expected 0", bus_if.ffi_grt);
            end
            @(negedge clk);
        end
        bus_if.ffi_req = 1'b0;
        checks++;
        if (bus_if.ffo_req !== 1'b1 || bus_if.ffo_bus !== 8'h00) begin
            errors++;
            $display("FAIL full_head: req=%b bus=%h expected req=1 bus=00", bus_if.ffo_req, bus_if.ffo_bus);
        end
    endtask

    task automatic test_drain();
        bus_if.ffo_grt = 1'b1;
        @(negedge clk);
        bus_if.ffo_grt = 1'b0;
        checks++;
        if (bus_if.ffo_bus !== 8'h01) begin
            errors++; $display("FAIL drain_head: got %h expected 01", bus_if.ffo_bus);
        end
        for (int k = 0; k <= LAT; k++) begin
            checks++;
            if (bus_if.ffi_grt !== (k == LAT)) begin
                errors++;
                $display("FAIL drain_grt_release: edge M+%0d ffi_grt got %b expected %b", k, bus_if.ffi_grt, (k == LAT));
            end
            if (k < LAT) @(negedge clk);
        end
        for (int e = 1; e < FF; e++) begin
            checks++;
            if (bus_if.ffo_req !== 1'b1 || bus_if.ffo_bus !== DW'(e)) begin
                errors++;
                $display("FAIL drain_order: req=%b bus=%h expected req=1 bus=%h", bus_if.ffo_req, bus_if.ffo_bus, DW'(e));
            end
            bus_if.ffo_grt = 1'b1;
            @(negedge clk);
            bus_if.ffo_grt = 1'b0;
        end
        repeat (LAT + 2) begin
            checks++;
            if (bus_if.ffo_req !== 1'b0) begin
                errors++; $display("FAIL drain_empty: ffo_req got %b expected 0", bus_if.ffo_req);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_streaming();
        int  wcum[$];
        int  rcum[$];
        int  t;
        int  wcnt;
        int  rcnt;
        int  w_seen;
        int  r_seen;
        bit  exp_grt;
        bit  exp_req;
        bit  wreq;
        bit  rgrt;
        wcum.push_back(0);
        rcum.push_back(0);
        t = 0; wcnt = 0; rcnt = 0;
        while (rcnt < 256 && t < 4000) begin
            w_seen  = (t - LAT >= 0) ? wcum[t-LAT] : 0;
            r_seen  = (t - LAT >= 0) ? rcum[t-LAT] : 0;
            exp_grt = (wcum[t] - r_seen) < FF;
            exp_req = (w_seen - rcum[t]) > 0;
            checks++;
            if (bus_if.ffi_grt !== exp_grt) begin
                errors++; $display("FAIL stream_grt: cycle %0d got %b expected %b", t, bus_if.ffi_grt, exp_grt);
            end
            checks++;
            if (bus_if.ffo_req !== exp_req) begin
                errors++; $display("FAIL stream_req: cycle %0d got %b expected %b", t, bus_if.ffo_req, exp_req);
            end
            if (exp_req) begin
                checks++;
                if (bus_if.ffo_bus !== DW'(rcnt % 256)) begin
                    errors++;
                    $display("FAIL stream_data: read %0d got %h expected %h", rcnt, bus_if.ffo_bus, DW'(rcnt % 256));
                end
            end
            wreq = 1'($urandom_range(0, 1));
            rgrt = 1'($urandom_range(0, 1));
            bus_if.ffi_req = wreq;
            bus_if.ffi_bus = DW'(wcnt % 256);
            bus_if.ffo_grt = rgrt;
            if (wreq && exp_grt) wcnt++;
            if (rgrt && exp_req) rcnt++;
            wcum.push_back(wcnt);
            rcum.push_back(rcnt);
            t++;
            @(negedge clk);
        end
        bus_if.ffi_req = 1'b0;
        bus_if.ffo_grt = 1'b0;
        checks++;
        if (rcnt < 256) begin
            errors++; $display("FAIL stream_timeout: reads %0d expected 256", rcnt);
        end
    endtask

    task automatic test_reset_mid();
        bus_if.ffi_req = 1'b1;
        bus_if.ffi_bus = 8'hC1;
        @(negedge clk);
        bus_if.ffi_bus = 8'hC2;
        @(negedge clk);
        bus_if.ffi_req = 1'b0;
        repeat (LAT + 1) @(negedge clk);
        checks++;
        if (bus_if.ffo_req !== 1'b1) begin
            errors++; $display("FAIL midreset_pre_req: got %b expected 1", bus_if.ffo_req);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus_if.ffo_req !== 1'b0 || bus_if.ffi_grt !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async: req=%b grt=%b expected 0 0", bus_if.ffo_req, bus_if.ffi_grt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus_if.ffi_grt !== 1'b1) begin
            errors++; $display("FAIL midreset_grt: got %b expected 1", bus_if.ffi_grt);
        end
        repeat (LAT + 3) begin
            checks++;
            if (bus_if.ffo_req !== 1'b0) begin
                errors++; $display("FAIL midreset_empty: ffo_req got %b expected 0", bus_if.ffo_req);
            end
            @(negedge clk);
        end
        bus_if.ffi_req = 1'b1;
        bus_if.ffi_bus = 8'h3C;
        @(negedge clk);
        bus_if.ffi_req = 1'b0;
        repeat (LAT) @(negedge clk);
        checks++;
        if (bus_if.ffo_req !== 1'b1 || bus_if.ffo_bus !== 8'h3C) begin
            errors++;
            $display("FAIL midreset_restart: req=%b bus=%h expected req=1 bus=3c", bus_if.ffo_req, bus_if.ffo_bus);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        bus_if.ffi_bus = '0;
        bus_if.ffi_req = 1'b0;
        bus_if.ffo_grt = 1'b0;
        test_reset();
        test_single_word();
        test_fill();
        test_drain();
        test_streaming();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sockit_cdc_fifo.md
Name: sockit_cdc_fifo

Overview:
- Single-clock elastic FIFO with the same request/grant handshake and pointer architecture as the dual-clock crossing FIFO.
- Data words enter on the ffi port and leave on the ffo port in order, with no loss or duplication.
- Gray-coded read/write pointers pass through SS register stages, so latency matches the crossing FIFO. It is a drop-in where both sides share one clock.

Parameters:
- FF, 4: FIFO depth in entries; power of two, at least 2.
- SS, 2: pointer synchronization stages; at least 1.
- DW, 8: data width in bits.

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  reset, active-low.
- ffi_bus  input  DW  write data.
- ffi_req  input  1  write request.
- ffi_grt  output  1  write grant (FIFO not full).
- ffo_bus  output  DW  read data (head entry).
- ffo_req  output  1  read request (FIFO not empty).
- ffo_grt  input  1  read grant from consumer.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Transfers: write when ffi_req & ffi_grt at a rising clk edge; read when ffo_req & ffo_grt at a rising clk edge.
- Storage: FF x DW array, written at the write-pointer index. No reset on the storage array.
- Pointers: binary write and read counters, width log2(FF)+1, wrapping modulo 2*FF. Each has a registered gray-code copy.
- Pointer pipelines: the gray write pointer passes through SS registers toward the read side; the gray read pointer passes through SS registers toward the write side.
- Full: the write-side gray pointer equals the delayed read gray pointer with its two MSBs inverted. ffi_grt = ~full.
- Empty: the read-side gray pointer equals the delayed write gray pointer. ffo_req = ~empty.
- ffo_bus: combinational read of mem[read pointer LSBs]. Valid whenever ffo_req is high; held stable until that word is read.
- Latency: a word written at edge N raises ffo_req after edge N+SS (empty-FIFO case).
- Grant release: a read at edge M that releases a full FIFO raises ffi_grt after edge M+SS.
- Reset (rst_n low, asynchronous):
  - all pointers and pipeline stages clear to 0;
  - ffo_req = 0;
  - ffi_grt = 0, held by a registered ready flag cleared by reset and set on the first rising edge after rst_n deasserts;
  - ffo_bus is don't-care.
- Simultaneous read and write, FIFO neither empty nor full: both take effect in the same cycle, and the occupancy seen by each side reflects the other side only after SS cycles.
- Writing while full or reading while empty cannot happen: a transfer requires the grant, so it is inherently blocked. No error flags.
- Wrap-around: pointers wrap without a glitch. Ordering holds across any number of wraps; at least 256 words with FF=4.
- Reset in mid-operation: contents are discarded and the FIFO restarts empty.

Optional Feature:
- Macro: SOCKIT_CDC_SYNC_EN.
- When defined: SS-stage pointer pipelines, as described in Behaviour.
- When undefined: SS is ignored and pointers are compared directly with no extra stages.
  - A write at edge N raises ffo_req after edge N.
  - A read from a full FIFO raises ffi_grt after the same edge.
  - Handshake, ordering and reset rules are unchanged.

Test Plan:
- Reset then idle (FF=4, SS=2, DW=8):
  - ffi_grt=0 and ffo_req=0 while rst_n=0;
  - ffi_grt=1 after the first edge following release;
  - ffo_req stays 0.
- Single word: write 0xA5 at edge N with ffo_grt=0 -> ffo_req=1 after edge N+2, ffo_bus=0xA5; assert ffo_grt -> one read, then ffo_req=0.
- Fill: hold ffo_grt=0 and write 0,1,2,3 -> ffi_grt=0 after the 4th write; a 5th request is not accepted; ffo_bus=0.
- Drain full FIFO: assert ffo_grt for one cycle at edge M -> ffi_grt=1 after edge M+2; ffo_bus then shows 1.
- Random streaming: ffi_req and ffo_grt each at ~50% probability; write data = write count -> 256 reads, each equal to the read count mod 256, zero mismatches.
- Macro off: repeat the single-word test -> ffo_req=1 after edge N (1-cycle latency); the streaming test still reports zero errors.
